uart_tx_feeder: RTL and testbench
=================================

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 1_048_575, maximum cycles to wait for tx_done after a launch.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 wr_en  in  1  push request from the register block, one byte per cycle.
REQ-006 wr_data  in  8  byte to push.
REQ-007 enable  in  1  when 1, frames may be launched; when 0, bytes stay queued.
REQ-008 ovf_clr  in  1  clears the overflow and timeout flags.
REQ-009 tx_done  in  1  one-cycle completion pulse from the UART transmitter.
REQ-010 tx_start  out  1  one-cycle launch pulse to the UART transmitter.
REQ-011 tx_data  out  8  byte for the transmitter; stable from tx_start until the next launch.
REQ-012 full  out  1  level == DEPTH.
REQ-013 empty  out  1  level == 0.
REQ-014 level  out  $clog2(DEPTH)+1  bytes currently queued.
REQ-015 busy  out  1  FSM not in IDLE.
REQ-016 overflow  out  1  sticky; a push was rejected.
REQ-017 timeout  out  1  sticky; tx_done did not arrive within TIMEOUT cycles.

Function
REQ-018 FIFO: circular buffer of DEPTH bytes; read/write pointers wrap modulo DEPTH; the level counter is separate.
REQ-019 A push with full=1 is dropped and sets overflow, including when a pop occurs in the same cycle.
REQ-020 Simultaneous accepted push and pop leaves level unchanged; push alone adds 1; pop alone subtracts 1.
REQ-021 FSM states: IDLE, LAUNCH, WAIT_DONE.
REQ-022 IDLE with enable=1 and empty=0: pop the head byte into tx_data and go to LAUNCH next cycle.
REQ-023 LAUNCH: tx_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_DONE.
REQ-024 WAIT_DONE: on tx_done=1, go to IDLE; otherwise increment the timeout counter.
REQ-025 In WAIT_DONE, when the timeout counter reaches TIMEOUT: set timeout and go to IDLE; the byte is considered lost.
REQ-026 tx_done seen in IDLE or LAUNCH is ignored.
REQ-027 Launch latency: a byte pushed into an empty FIFO while idle and enabled gives tx_start two cycles after the wr_en cycle (cycle 1: write; cycle 2: pop; cycle 3: tx_start).
REQ-028 Back-to-back gap: tx_done in cycle N gives the next tx_start in cycle N+2.
REQ-029 enable deasserted in LAUNCH or WAIT_DONE does not abort the current frame; it only blocks the next pop.
REQ-030 ovf_clr=1 clears both sticky flags; a set event in the same cycle has priority.
REQ-031 Timeout counter width is $clog2(TIMEOUT+1) bits; the counter saturates and never wraps.

Reset
REQ-032 rst_n=0 asynchronously forces: FSM=IDLE, pointers=0, level=0, empty=1, full=0, tx_start=0, tx_data=8'h00, overflow=0, timeout=0, timeout counter=0.
REQ-033 Reset mid-frame discards the queue and the in-flight byte; no tx_start pulse follows release.
REQ-034 FIFO storage is not reset.

Structure
REQ-035 A shared package uart_pkg holds the FSM state enum (tx_feed_state_t) and UART_DATA_W=8.
REQ-036 One sub-module, sync_fifo (parameterised width and depth, with push, pop, full, empty and level), holds the buffer; uart_tx_feeder contains the FSM, timeout and flag logic.
REQ-037 Outputs tx_start and tx_data connect directly to the TX modport inputs of uart_if.

Verification
REQ-038 Reset with enable=1, push 8'hA5 -> tx_start in the second cycle after the push, with tx_data=8'hA5; busy=1 until 1 cycle after tx_done.
REQ-039 With enable=0, push 16 bytes 8'h00..8'h0F -> full=1, level=16; a 17th push sets overflow; set enable=1 and answer each tx_done -> bytes emitted in order 8'h00..8'h0F, with tx_starts 2 cycles after each tx_done.
REQ-040 With TIMEOUT=20, launch 8'h3C and withhold tx_done -> timeout=1 after 20 WAIT_DONE cycles, FSM returns to IDLE, next byte launches; ovf_clr clears the flag.
REQ-041 Push in the same cycle as a pop with level=16 -> push dropped, overflow=1, level=15; with level=5 -> level stays 5.
REQ-042 Assert rst_n=0 during WAIT_DONE with 4 bytes queued -> all outputs take reset values immediately; no tx_start after release until a new push.
REQ-043 Pulse tx_done while in IDLE with empty=1 -> no state change and no tx_start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width and feeder FSM states.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } tx_feed_state_t;

endpackage

// File: rtl/uart_if.sv
// Handshake between the byte feeder (master) and the UART transmitter (slave).
interface uart_if;
    import uart_pkg::*;

    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_done
    );

endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with a separate level counter and a registered read port.
// pop_data updates only on an accepted pop, so it holds the last popped word.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full     = (level_reg == LW'(DEPTH));
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign pop_data = rd_data_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            level_reg   <= '0;
            rd_data_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                rd_data_reg <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Queues bytes from the register block and launches them one at a time into a UART
// transmitter, with a completion timeout and sticky overflow/timeout flags.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1_048_575
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   enable,
    input  logic                   ovf_clr,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic                   overflow,
    output logic                   timeout,
    uart_if.master                 tx
);

    localparam int CW = $clog2(TIMEOUT + 1);

    tx_feed_state_t state_reg;
    tx_feed_state_t state_next;
    logic [CW-1:0]  wait_cnt_reg;
    logic [CW-1:0]  wait_cnt_next;
    logic           pop;
    logic           timeout_set;
    logic           overflow_set;
    logic           overflow_reg;
    logic           timeout_reg;

    // The FIFO's held read register is the transmitter's data bus directly.
    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (tx.tx_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        pop           = 1'b0;
        timeout_set   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && !empty) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                wait_cnt_next = '0;
                state_next    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx.tx_done) begin
                    state_next = IDLE;
                end else begin
                    // Counts waited cycles; reaching TIMEOUT means the frame is abandoned.
                    wait_cnt_next = (wait_cnt_reg == CW'(TIMEOUT)) ? wait_cnt_reg
                                                                   : wait_cnt_reg + CW'(1);
                    if (wait_cnt_next == CW'(TIMEOUT)) begin
                        timeout_set = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    assign overflow_set = wr_en && full;

    // A set event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end else if (ovf_clr) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign tx.tx_start = (state_reg == LAUNCH);
    assign busy        = (state_reg != IDLE);
    assign overflow    = overflow_reg;
    assign timeout     = timeout_reg;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed-sequence bench with random payloads; a byte queue models the FIFO contents
// and each launch is checked against the byte the queue says must come next.
module tb_uart_tx_feeder;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 20;

    logic                   clk     = 1'b0;
    logic                   rst_n   = 1'b0;
    logic                   wr_en   = 1'b0;
    logic [7:0]             wr_data = 8'h00;
    logic                   enable  = 1'b0;
    logic                   ovf_clr = 1'b0;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] level;
    logic                   busy;
    logic                   overflow;
    logic                   timeout;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q[$];
    logic [7:0] cur;

    uart_if u_if ();

    uart_tx_feeder #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .enable   (enable),
        .ovf_clr  (ovf_clr),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .overflow (overflow),
        .timeout  (timeout),
        .tx       (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accepted only while the modelled queue has room, judged before any same-cycle pop.
    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
    endtask

    // Entered in a LAUNCH cycle with cur holding the expected byte; serves n frames.
    task automatic serve(input int n, input int hold_idx);
        int d;
        for (int i = 0; i < n; i++) begin
            chk("launch_pulse", u_if.tx_start, 1);
            chk("tx_data_order", u_if.tx_data, cur);
            chk("level_at_launch", level, model_q.size());
            tick();
            chk("single_pulse", u_if.tx_start, 0);
            if (i == hold_idx) enable = 1'b0;
            d = $urandom_range(0, 3);
            repeat (d) tick();
            chk("busy_wait", busy, 1);
            u_if.tx_done = 1'b1;
            tick();
            u_if.tx_done = 1'b0;
            chk("busy_after_done", busy, 0);
            chk("tx_data_hold", u_if.tx_data, cur);
            if (i < n - 1) begin
                if (i == hold_idx) begin
                    tick();
                    chk("enable_low_no_pop", busy, 0);
                    chk("enable_low_level", level, model_q.size());
                    enable = 1'b1;
                end
                cur = model_q.pop_front();
                tick();
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        bit         saw;
        u_if.tx_done = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_start", u_if.tx_start, 0);
        chk("rst_tx_data", u_if.tx_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        tick();

        // Single byte launch latency
        enable  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        model_push(8'hA5);
        tick();
        wr_en = 1'b0;
        chk("latency_level", level, 1);
        chk("latency_no_early_start", u_if.tx_start, 0);
        cur = model_q.pop_front();
        tick();
        serve(1, -1);

        // Fill with enable low, then overflow with a simultaneous clear
        enable = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            model_push(8'(i));
            tick();
        end
        chk("fill_full", full, 1);
        chk("fill_level", level, DEPTH);
        chk("fill_no_overflow", overflow, 0);
        wr_data = 8'h10;
        ovf_clr = 1'b1;
        model_push(8'h10);
        tick();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        chk("ovf_set_priority", overflow, 1);
        chk("ovf_level", level, DEPTH);
        chk("enable_low_blocks", busy, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clear", overflow, 0);

        // Push in the pop cycle at full: dropped
        enable  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        model_push(8'hEE);
        cur = model_q.pop_front();
        tick();
        wr_en = 1'b0;
        chk("ovf_push_pop_full", overflow, 1);
        chk("level_after_drop", level, DEPTH - 1);
        serve(DEPTH, -1);

        // Push in the pop cycle at level 5: level unchanged
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b       = 8'($urandom);
            wr_en   = 1'b1;
            wr_data = b;
            model_push(b);
            tick();
        end
        chk("level5", level, 5);
        enable  = 1'b1;
        b       = 8'($urandom);
        wr_data = b;
        model_push(b);
        cur = model_q.pop_front();
        tick();
        wr_en = 1'b0;
        chk("level5_push_pop", level, 5);
        serve(6, 2);

        // Completion timeout
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        model_push(8'h3C);
        tick();
        b       = 8'($urandom);
        wr_data = b;
        model_push(b);
        cur = model_q.pop_front();
        tick();
        wr_en = 1'b0;
        chk("to_launch", u_if.tx_start, 1);
        chk("to_data", u_if.tx_data, 8'h3C);
        tick();
        repeat (TIMEOUT - 1) tick();
        chk("timeout_not_early", timeout, 0);
        chk("timeout_busy_last_wait", busy, 1);
        tick();
        chk("timeout_set", timeout, 1);
        chk("timeout_idle", busy, 0);
        cur = model_q.pop_front();
        tick();
        serve(1, -1);
        chk("timeout_sticky", timeout, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("timeout_clear", timeout, 0);
        chk("overflow_clear2", overflow, 0);

        // Asynchronous reset in WAIT_DONE with 4 bytes queued
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b       = 8'($urandom);
            wr_en   = 1'b1;
            wr_data = b;
            model_push(b);
            tick();
        end
        wr_en  = 1'b0;
        enable = 1'b1;
        cur = model_q.pop_front();
        tick();
        chk("rst_mid_launch", u_if.tx_start, 1);
        tick();
        chk("rst_mid_level", level, 4);
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        chk("async_rst_busy", busy, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_empty", empty, 1);
        chk("async_rst_tx_start", u_if.tx_start, 0);
        chk("async_rst_tx_data", u_if.tx_data, 0);
        tick();
        rst_n = 1'b1;
        saw   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (u_if.tx_start === 1'b1) saw = 1'b1;
        end
        chk("no_start_after_reset", saw, 0);

        // tx_done while idle and empty
        u_if.tx_done = 1'b1;
        tick();
        u_if.tx_done = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_start", u_if.tx_start, 0);
        tick();
        chk("idle_done_start2", u_if.tx_start, 0);

        // A new push launches normally
        b       = 8'($urandom);
        wr_en   = 1'b1;
        wr_data = b;
        model_push(b);
        tick();
        wr_en = 1'b0;
        cur = model_q.pop_front();
        tick();
        serve(1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
